// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Entry M drives the execute side; entry S catches the one beat that can
// arrive while M is stalled. flush_i squashes both entries plus the incoming beat.
// Optional perf counters (stall_cnt_o, flush_cnt_o) when ID_EX_SKID_PERF_EN is defined.
module id_ex_skid_stage #(
  parameter int WIDTH  = 32,
  parameter int REGW   = 5,
  parameter int CTRL_W = 10
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic [WIDTH-1:0]  rd1_i,
  input  logic [WIDTH-1:0]  rd2_i,
  input  logic [WIDTH-1:0]  sign_imm_i,
  input  logic [WIDTH-1:0]  se_shamt_i,
  input  logic [WIDTH-1:0]  pc_plus4_i,
  input  logic [REGW-1:0]   rs_i,
  input  logic [REGW-1:0]   rt_i,
  input  logic [REGW-1:0]   rd_i,
  input  logic [5:0]        funct_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  rd1_o,
  output logic [WIDTH-1:0]  rd2_o,
  output logic [WIDTH-1:0]  sign_imm_o,
  output logic [WIDTH-1:0]  se_shamt_o,
  output logic [WIDTH-1:0]  pc_plus4_o,
  output logic [REGW-1:0]   rs_o,
  output logic [REGW-1:0]   rt_o,
  output logic [REGW-1:0]   rd_o,
  output logic [5:0]        funct_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef ID_EX_SKID_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  sign_imm;
    logic [WIDTH-1:0]  se_shamt;
    logic [WIDTH-1:0]  pc_plus4;
    logic [REGW-1:0]   rs;
    logic [REGW-1:0]   rt;
    logic [REGW-1:0]   rd;
    logic [5:0]        funct;
    logic [CTRL_W-1:0] ctrl;
  } payload_t;

  payload_t in_p, m_q, m_d, s_q, s_d;
  logic     m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic     rdy_q;
  logic     accept, drain;

  assign in_p = '{rd1: rd1_i, rd2: rd2_i, sign_imm: sign_imm_i, se_shamt: se_shamt_i,
                  pc_plus4: pc_plus4_i, rs: rs_i, rt: rt_i, rd: rd_i,
                  funct: funct_i, ctrl: ctrl_i};

  assign accept = valid_i & rdy_q;
  assign drain  = m_vld_q & ready_i;

  // Next-state for both entries; flush beats drain, drain beats a plain accept.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (drain) begin
      if (s_vld_q) begin
        // ready_o is low while S is full, so no accept can coincide here
        m_d     = s_q;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_d = in_p;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!m_vld_q) begin
        m_d     = in_p;
        m_vld_d = 1'b1;
      end else begin
        s_d     = in_p;
        s_vld_d = 1'b1;
      end
    end
  end

  // State registers; ready is registered from next S occupancy so ready_i never
  // reaches ready_o combinationally.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= !s_vld_d;
    end
  end

  assign ready_o    = rdy_q;
  assign valid_o    = m_vld_q;
  assign rd1_o      = m_q.rd1;
  assign rd2_o      = m_q.rd2;
  assign sign_imm_o = m_q.sign_imm;
  assign se_shamt_o = m_q.se_shamt;
  assign pc_plus4_o = m_q.pc_plus4;
  assign rs_o       = m_q.rs;
  assign rt_o       = m_q.rt;
  assign rd_o       = m_q.rd;
  assign funct_o    = m_q.funct;
  // Bubbles must never carry write enables into execute
  assign ctrl_o     = m_vld_q ? m_q.ctrl : '0;

`ifdef ID_EX_SKID_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Saturating counters of execute stall cycles and flush edges.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (m_vld_q && !ready_i && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_i && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage: accepted beats are queued with their
// expected payload; a negedge monitor pops on every execute-side handshake.
module tb_id_ex_skid_stage;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, sh, pc;
    logic [4:0]  rs, rt, rd;
    logic [5:0]  funct;
    logic [9:0]  ctrl;
  } pl_t;

  logic clk = 0, reset_ni = 0, valid_i = 0, flush_i = 0, ready_i = 0;
  logic ready_o, valid_o;
  logic [31:0] rd1_i = 0, rd2_i = 0, sign_imm_i = 0, se_shamt_i = 0, pc_plus4_i = 0;
  logic [4:0]  rs_i = 0, rt_i = 0, rd_i = 0;
  logic [5:0]  funct_i = 0;
  logic [9:0]  ctrl_i = 0;
  logic [31:0] rd1_o, rd2_o, sign_imm_o, se_shamt_o, pc_plus4_o;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [5:0]  funct_o;
  logic [9:0]  ctrl_o;
`ifdef ID_EX_SKID_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int tests = 0, fails = 0;
  pl_t q[$];

  id_ex_skid_stage #(.WIDTH(32), .REGW(5), .CTRL_W(10)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .rd1_i(rd1_i), .rd2_i(rd2_i), .sign_imm_i(sign_imm_i),
    .se_shamt_i(se_shamt_i), .pc_plus4_i(pc_plus4_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .funct_i(funct_i), .ctrl_i(ctrl_i), .valid_o(valid_o),
    .ready_i(ready_i), .rd1_o(rd1_o), .rd2_o(rd2_o), .sign_imm_o(sign_imm_o),
    .se_shamt_o(se_shamt_o), .pc_plus4_o(pc_plus4_o), .rs_o(rs_o), .rt_o(rt_o),
    .rd_o(rd_o), .funct_o(funct_o), .ctrl_o(ctrl_o)
`ifdef ID_EX_SKID_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bench-side payload derived from the PC so every field is distinct
  function automatic pl_t mk(input logic [31:0] pc);
    pl_t p;
    p.rd1 = pc * 3 + 1;  p.rd2 = ~pc;  p.imm = pc << 8;  p.sh = pc >> 2;  p.pc = pc;
    p.rs = pc[6:2];  p.rt = pc[6:2] + 5'd1;  p.rd = pc[6:2] + 5'd2;
    p.funct = pc[7:2];  p.ctrl = pc[9:0] | 10'h200;
    return p;
  endfunction

  task automatic drive(input logic [31:0] pc);
    pl_t p;
    p = mk(pc);
    valid_i = 1;  rd1_i = p.rd1;  rd2_i = p.rd2;  sign_imm_i = p.imm;  se_shamt_i = p.sh;
    pc_plus4_i = p.pc;  rs_i = p.rs;  rt_i = p.rt;  rd_i = p.rd;  funct_i = p.funct;
    ctrl_i = p.ctrl;
  endtask

  // Offer a beat (called just after a posedge) and hold it until accepted
  task automatic send(input logic [31:0] pc);
    logic acc;
    acc = 0;
    drive(pc);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
    valid_i = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected-queue maintenance: push on accept, drop everything on flush/reset
  always @(posedge clk) begin
    if (!reset_ni || flush_i) q.delete();
    else if (valid_i && ready_o) q.push_back(mk(pc_plus4_i));
  end

  // Monitor: compare each execute handshake against the scoreboard head
  always @(negedge clk) begin
    if (reset_ni && valid_o && ready_i) begin
      if (q.size() == 0) check("unexpected_out", {32'h0, pc_plus4_o}, 64'hDEAD);
      else begin
        pl_t e, a;
        e = q.pop_front();
        a = '{rd1: rd1_o, rd2: rd2_o, imm: sign_imm_o, sh: se_shamt_o, pc: pc_plus4_o,
              rs: rs_o, rt: rt_o, rd: rd_o, funct: funct_o, ctrl: ctrl_o};
        check("sb_pc", {32'h0, a.pc}, {32'h0, e.pc});
        check("sb_payload", (a == e) ? 64'd1 : 64'd0, 64'd1);
      end
    end
    if (reset_ni && !valid_o) check("bubble_ctrl", {54'h0, ctrl_o}, 64'h0);
  end

  initial begin
    // Reset held with a live beat offered
    reset_ni = 0;  ready_i = 1;  drive(32'h99);  ctrl_i = 10'h3FF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {63'h0, valid_o}, 0);
    check("rst_ctrl", {54'h0, ctrl_o}, 0);
    check("rst_ready", {63'h0, ready_o}, 0);
    check("rst_pc", {32'h0, pc_plus4_o}, 0);
    reset_ni = 1;  valid_i = 0;
    @(negedge clk);
    check("rel_ready", {63'h0, ready_o}, 1);

    // Streaming 4,8,12,16 with valid_o continuous
    @(posedge clk); #1;
    drive(4);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k < 3) drive(8 + 4 * k); else valid_i = 0;
      @(negedge clk);
      check("stream_valid", {63'h0, valid_o}, 1);
    end
    cyc(2);
    @(negedge clk);
    check("stream_idle", {63'h0, valid_o}, 0);

    // Back-pressure: 4 held in M, 8 lands in S, 12 waits upstream
    @(posedge clk); #1;
    ready_i = 0;
    send(4);
    send(8);
    drive(12);
    @(negedge clk);
    check("bp_ready_low", {63'h0, ready_o}, 0);
    check("bp_hold_pc", {32'h0, pc_plus4_o}, 4);
    @(negedge clk);
    check("bp_ready_low2", {63'h0, ready_o}, 0);
    check("bp_hold_pc2", {32'h0, pc_plus4_o}, 4);
    ready_i = 1;
    @(negedge clk);
    check("bp_drain_v1", {63'h0, valid_o}, 1);
    check("bp_drain_pc1", {32'h0, pc_plus4_o}, 8);
    check("bp_ready_back", {63'h0, ready_o}, 1);
    @(posedge clk); #1;   // 12 accepted here, 8 drained
    valid_i = 0;
    @(negedge clk);
    check("bp_drain_v2", {63'h0, valid_o}, 1);
    check("bp_drain_pc2", {32'h0, pc_plus4_o}, 12);
    cyc(2);

    // Flush with M=20, S=24, 28 offered
    ready_i = 0;
    send(20);
    send(24);
    drive(28);  flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0;  valid_i = 0;
    @(negedge clk);
    check("fl_valid", {63'h0, valid_o}, 0);
    check("fl_ctrl", {54'h0, ctrl_o}, 0);
    check("fl_ready", {63'h0, ready_o}, 1);
    // Flush discards a beat that would otherwise be accepted
    @(posedge clk); #1;
    drive(32);  flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0;  valid_i = 0;
    @(negedge clk);
    check("fl_discard", {63'h0, valid_o}, 0);
    ready_i = 1;
    cyc(2);

    // Bubble: enable_wreg on the bus with valid_i low
    valid_i = 0;  ctrl_i = 10'h001;
    repeat (3) begin
      @(negedge clk);
      check("bubble_v", {63'h0, valid_o}, 0);
      check("bubble_c", {54'h0, ctrl_o}, 0);
    end

    // Reset mid-operation discards both entries
    @(posedge clk); #1;
    ready_i = 0;
    send(40);
    send(44);
    reset_ni = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_valid", {63'h0, valid_o}, 0);
    check("mrst_ready", {63'h0, ready_o}, 0);
    check("mrst_pc", {32'h0, pc_plus4_o}, 0);
    reset_ni = 1;
    @(negedge clk);
    check("mrst_rel", {63'h0, ready_o}, 1);
    check("mrst_empty", {63'h0, valid_o}, 0);
    ready_i = 1;

`ifdef ID_EX_SKID_PERF_EN
    check("perf_rst_stall", {32'h0, stall_cnt_o}, 0);
    check("perf_rst_flush", {32'h0, flush_cnt_o}, 0);
    @(posedge clk); #1;
    ready_i = 0;
    drive(50);
    @(posedge clk); #1;   // 50 into M; no stall counted on this edge
    valid_i = 0;
    repeat (4) @(posedge clk);
    #1;                   // 4 stall edges so far
    @(posedge clk); #1;   // 5th stall edge
    ready_i = 1;
    @(posedge clk); #1;   // drain
    flush_i = 1;
    cyc(2);
    flush_i = 0;
    @(negedge clk);
    check("perf_stall5", {32'h0, stall_cnt_o}, 5);
    check("perf_flush2", {32'h0, flush_cnt_o}, 2);
    ready_i = 0;
    send(60);             // 60 now in M, stalled
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_q;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("perf_sat", {32'h0, stall_cnt_o}, 64'hFFFF_FFFF);
    ready_i = 1;
    cyc(2);
`endif

    cyc(3);
    check("sb_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_ex_skid_stage.md
Name: id_ex_skid_stage

Overview:
- Parametrised decode→execute pipeline stage for the pipelined MIPS core, replacing a plain always-enabled ID/EX register.
- Adds a valid/ready handshake with a 2-entry skid buffer, so execute back-pressure (ready_i low) never drops or duplicates an instruction.
- Adds flush for branch/jump squash.
- Data widths, register-address width and control-bus width are all parametrised.

Parameters:
- WIDTH, 32, datapath word width (rd1, rd2, sign_imm, se_shamt, pc_plus4).
- REGW, 5, register-file address width (rs, rt, rd).
- CTRL_W, 10, control bus width; bit map: [0] enable_wreg, [1] mem_to_reg, [2] enable_wmem, [3] branch, [4] pc_j, [6:5] alu_alt_ctrl, [7] b_alu_input, [8] apply_shift, [9] reg_dst_rtrd.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  synchronous active-low reset.
- valid_i  in  1  decode offers an instruction.
- ready_o  out  1  stage can accept; registered.
- flush_i  in  1  squash stage contents and any beat offered this cycle.
- rd1_i, rd2_i  in  WIDTH  register operands.
- sign_imm_i, se_shamt_i, pc_plus4_i  in  WIDTH  immediates, PC+4.
- rs_i, rt_i, rd_i  in  REGW  register addresses (rs new, for forwarding).
- funct_i  in  6  ALU function field.
- ctrl_i  in  CTRL_W  control bus.
- valid_o  out  1  execute-side instruction valid.
- ready_i  in  1  execute accepts.
- rd1_o, rd2_o, sign_imm_o, se_shamt_o, pc_plus4_o  out  WIDTH  registered copies.
- rs_o, rt_o, rd_o  out  REGW  registered copies.
- funct_o  out  6  registered copy.
- ctrl_o  out  CTRL_W  registered control; forced 0 when valid_o=0.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S, each holding a payload and a valid bit.
- Accept: valid_i & ready_o. Drain: valid_o & ready_i.
- ready_o = !S.valid, registered (no combinational path ready_i→ready_o).
- Accept with M empty, or with M draining this cycle: payload loads into M, giving latency 1 cycle input→output.
- Accept with M full and not draining: payload loads into S.
- Drain with S full: S moves into M, S.valid←0. Drain with S empty and no accept: M.valid←0.
- Simultaneous accept and drain with S empty: M takes the new payload, M.valid stays 1.
- Order is strictly preserved; no duplication, no drop.
- flush_i=1 at an edge: M.valid←0, S.valid←0, and the beat offered this cycle is discarded even if valid_i & ready_o. flush has priority over accept and drain.
- ready_o is 1 in the cycle after a flush.
- Bubble safety: ctrl_o = M.valid ? M.ctrl : 0. Other data outputs hold their last loaded value when invalid; they are don't-care for checking.
- Reset (reset_ni low at an edge): M.valid=S.valid=0; all payload registers 0; valid_o=0; ctrl_o=0; all data outputs 0.
- ready_o=0 while reset_ni is low; ready_o=1 from the first edge after release.
- Reset mid-operation discards both entries; the register file sees no write from them.
- Payload registers update only on load, so holding valid_i with ready_o low changes nothing.
- Inputs are not required to stay stable when ready_o=0.
- Upstream holds valid_i until ready_o is seen (standard valid/ready).
- X on payload inputs while valid_i=0 must not reach ctrl_o.

Optional Feature:
- Macro: ID_EX_SKID_PERF_EN.
- Defined: adds outputs stall_cnt_o (32) and flush_cnt_o (32).
  - stall_cnt_o counts cycles with valid_o & !ready_i.
  - flush_cnt_o counts edges with flush_i=1.
  - Both counters saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold reset_ni=0 for 3 cycles with valid_i=1 and ctrl_i=0x3FF → valid_o=0, ctrl_o=0, ready_o=0. Release → ready_o=1 next cycle.
- Streaming: ready_i=1, feed pc_plus4 = 4, 8, 12, 16 back-to-back → same sequence on pc_plus4_o, each 1 cycle later, valid_o continuous.
- Back-pressure: ready_i=0 after the first beat (pc=4), feed pc=8, 12 → pc=8 enters S, ready_o falls, pc=12 is held upstream. Raise ready_i → output 4, 8, 12 in order, no gaps once draining.
- Flush: M=pc 20, S=pc 24, valid_i=1 with pc 28, flush_i=1 → next cycle valid_o=0, ctrl_o=0, ready_o=1. pc 28 never appears.
- Bubble: valid_i=0 with ctrl_i=0x001 (enable_wreg) → ctrl_o stays 0.
- With ID_EX_SKID_PERF_EN: 5 stall cycles plus 2 flushes → stall_cnt_o=5, flush_cnt_o=2. Preload stall_cnt to 0xFFFF_FFFE via force, 3 further stall cycles → stall_cnt_o=0xFFFF_FFFF.
